// File: rtl/uart_block_serializer_if.sv
// Bundle between the block serializer, its upstream producer and the UART transmitter.
// Handshake: a block moves when in_valid && in_ready are both high at a posedge clk;
// in_data must be stable in that cycle, and in_valid may stay high into the next block.
interface uart_block_serializer_if #(
  parameter int NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_data;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_done;
  logic                  busy;
  logic                  block_done;
  logic                  err;

  modport master (
    output in_valid, in_data, tx_done,
    input  in_ready, tx_start, tx_data, busy, block_done, err
  );

  modport slave (
    input  in_valid, in_data, tx_done,
    output in_ready, tx_start, tx_data, busy, block_done, err
  );
endinterface

// File: rtl/uart_block_serializer.sv
// Feeds a multi-byte block to a UART transmitter one byte per start/done exchange,
// MSB byte first, with an idle gap between bytes and an optional done watchdog.
module uart_block_serializer #(
  parameter int NBYTES  = 16,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_block_serializer_if.slave bus,
  output logic [1:0]             dbg_state
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] byte_q, byte_d;
  logic [31:0]   gap_q, gap_d;
  logic [31:0]   wd_q, wd_d;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  logic          bdone_q, bdone_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      bdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      start_q <= start_d;
      data_q  <= data_d;
      bdone_q <= bdone_d;
      err_q   <= err_d;
    end
  end

  // tx_start is registered on the transition into START, so it is high exactly while in START.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    start_d = 1'b0;
    data_d  = data_q;
    bdone_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          shift_d = bus.in_data;
          byte_d  = '0;
          start_d = 1'b1;
          data_d  = bus.in_data[W-1 -: 8];
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          shift_d = shift_q << 8;
          if (byte_q == CW'(NBYTES - 1)) begin
            bdone_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + CW'(1);
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (TIMEOUT > 0 && (wd_q + 32'd1) == 32'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      S_GAP: begin
        if (gap_q == 32'(GAP - 1)) begin
          start_d = 1'b1;
          data_d  = shift_q[W-1 -: 8];
          state_d = S_START;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.tx_start   = start_q;
  assign bus.tx_data    = data_q;
  assign bus.block_done = bdone_q;
  assign bus.err        = err_q;
  assign dbg_state      = state_q;
endmodule
